pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Merges the per-cycle load-use hazard flag with branch redirects and outstanding instruction/data memory transactions.
- Drives every pipeline-register write enable and flush, the PC write enable, and a fetch-discard flag.
- Tracks in-flight memory requests across cycles and flags stuck transactions with a watchdog.

Parameters:
TIMEOUT, 255, cycles a memory request may stay pending before mem_timeout sets; must be >= 1.
CNT_W, 32, width of each optional performance counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
load_use_hazard  in  1  ID consumes the destination of a load currently in EX
ex_redirect  in  1  branch/jump resolved taken in EX this cycle
imem_req  in  1  fetch issues an accepted instruction request this cycle
imem_resp  in  1  instruction response valid this cycle
dmem_req  in  1  MEM stage issues an accepted load/store this cycle
dmem_resp  in  1  data response valid this cycle
pc_we  out  1  PC update enable
if_id_we  out  1  IF/ID register enable
id_ex_we  out  1  ID/EX register enable
ex_mem_we  out  1  EX/MEM register enable
mem_wb_we  out  1  MEM/WB register enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
fetch_discard  out  1  current imem_resp belongs to a squashed fetch; drop it
stall_cause  out  2  0 none, 1 imem, 2 load-use, 3 dmem
mem_timeout  out  1  sticky watchdog flag
perf_imem_cnt  out  CNT_W  imem-wait stall cycles
perf_lu_cnt  out  CNT_W  load-use stall cycles
perf_dmem_cnt  out  CNT_W  dmem-wait stall cycles

Behaviour:
- Pending flags i_pend and d_pend:
  - Each sets on a req without a same-cycle resp.
  - Each clears on resp.
  - A req and resp in the same cycle is a zero-wait transaction and leaves the flag clear.
  - A req while the matching flag is already set is illegal; the flag stays set.
- Stall conditions (combinational from registered state plus current inputs):
  - dwait = (d_pend | dmem_req) & ~dmem_resp
  - iwait = (i_pend | imem_req) & ~imem_resp
- Outputs by condition, highest priority first:
  1. dwait: all five write enables 0, both flushes 0, stall_cause=3. The whole pipeline freezes and any redirect or load-use is held.
  2. ex_redirect: pc_we=1, if_id_flush=1, id_ex_flush=1, other enables 1, stall_cause=0. If iwait, set the registered discard flag.
  3. load_use_hazard: pc_we=0, if_id_we=0, id_ex_flush=1, remaining enables 1, stall_cause=2.
  4. iwait: pc_we=0, if_id_flush=1, remaining enables 1, stall_cause=1.
  5. Otherwise: all enables 1, flushes 0, stall_cause=0.
- Discard flag:
  - fetch_discard = discard & imem_resp.
  - discard clears on that response.
  - While discard is set, the squashed response does not end the imem wait: iwait is treated as 1 on the discarded response cycle.
- Watchdog:
  - A per-type wait counter increments each cycle its flag is pending and clears when the flag clears.
  - When the counter reaches TIMEOUT, mem_timeout sets and holds until reset.
  - The counter saturates at TIMEOUT.
- Reset (rst_n=0 at a clk edge):
  - i_pend, d_pend, discard, wait counters, mem_timeout and all perf counters clear.
  - Outputs during and after reset are the "otherwise" row: all enables 1, flushes 0, stall_cause=0, fetch_discard=0.
  - Reset mid-transaction abandons the transaction; a late response after reset is not tracked.
- Latency: all enables and flushes are combinational, same cycle as the inputs. Pending, discard and watchdog state updates take effect the next cycle.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined: perf_imem_cnt, perf_lu_cnt and perf_dmem_cnt each increment by 1 in every cycle whose stall_cause is 1, 2 or 3 respectively. Counters wrap modulo 2^CNT_W.
- Undefined: the three ports remain present and are tied to 0, and no counter flops are built.

Test Plan:
- Zero-wait: imem_req=imem_resp=1 every cycle, no hazards → all enables 1 and flushes 0 every cycle; stall_cause stays 0.
- Load-use: load_use_hazard=1 for 1 cycle → that cycle pc_we=0, if_id_we=0, id_ex_flush=1, stall_cause=2; the next cycle returns to all enables 1.
- Dmem wait:
  - Stimulus: dmem_req at cycle 0, dmem_resp at cycle 3, load_use_hazard=1 during cycle 1.
  - Required: cycles 0-2 have all enables 0 with stall_cause=3; cycle 3 advances.
  - Perf build: perf_dmem_cnt=3.
- Redirect during imem wait:
  - Stimulus: imem_req at cycle 0, ex_redirect at cycle 1, imem_resp at cycle 2, next imem_resp at cycle 4.
  - Required: cycle 1 has both flushes and pc_we=1; cycle 2 has fetch_discard=1 and stall_cause=1; cycle 4 has fetch_discard=0.
- Watchdog: TIMEOUT=4, imem_req with no resp → mem_timeout rises after 4 pending cycles and stays 1 after a later imem_resp.
- Reset mid-wait: d_pend set, rst_n=0 for 1 cycle → the next cycle has stall_cause=0, all enables 1, mem_timeout=0 and counters 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the RV32I pipeline datapath and its stall/flush sequencer.
// master = pipeline side (hazard and memory events), slave = pipeline_stall_ctrl.
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 32);
  logic             load_use_hazard;
  logic             ex_redirect;
  logic             imem_req;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             fetch_discard;
  logic [1:0]       stall_cause;
  logic             mem_timeout;
  logic [CNT_W-1:0] perf_imem_cnt;
  logic [CNT_W-1:0] perf_lu_cnt;
  logic [CNT_W-1:0] perf_dmem_cnt;

  modport master (
    output load_use_hazard, ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
    input  fetch_discard, stall_cause, mem_timeout, perf_imem_cnt, perf_lu_cnt, perf_dmem_cnt
  );

  modport slave (
    input  load_use_hazard, ex_redirect, imem_req, imem_resp, dmem_req, dmem_resp,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush,
    output fetch_discard, stall_cause, mem_timeout, perf_imem_cnt, perf_lu_cnt, perf_dmem_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline with memory watchdog.
// Optional stall-cycle counters are built when PIPE_STALL_PERF_EN is defined.
//
// fetch state  | meaning
// F_IDLE       | no instruction request outstanding
// F_PEND       | instruction request outstanding, response is live
// F_DROP       | nothing outstanding, next response belongs to a squashed fetch
// F_DROP_PEND  | request outstanding, its response belongs to a squashed fetch
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    F_IDLE      = 2'b00,
    F_PEND      = 2'b01,
    F_DROP      = 2'b10,
    F_DROP_PEND = 2'b11
  } fetch_state_t;

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  fetch_state_t    fetch_state, fetch_state_n;
  logic            d_pend, d_pend_n;
  logic            i_pend, discard;
  logic            i_pend_n, discard_n;
  logic            dwait, iwait;
  logic [WD_W-1:0] i_cnt, d_cnt, i_cnt_n, d_cnt_n;
  logic            timeout_q;
  logic [6:0]      en_row;
  logic [1:0]      cause;

  assign i_pend  = fetch_state[0];
  assign discard = fetch_state[1];

  assign dwait = (d_pend | bus.dmem_req) & ~bus.dmem_resp;
  // a squashed response must not release the fetch stall
  assign iwait = (i_pend | bus.imem_req) & (~bus.imem_resp | discard);

  always_comb begin
    en_row    = 7'b1111100;
    cause     = 2'd0;
    discard_n = discard & ~bus.imem_resp;
    if (rst_n) begin
      if (dwait) begin
        en_row = 7'b0000000;
        cause  = 2'd3;
      end else if (bus.ex_redirect) begin
        en_row = 7'b1111111;
        if (iwait) discard_n = 1'b1;
      end else if (bus.load_use_hazard) begin
        en_row = 7'b0011101;
        cause  = 2'd2;
      end else if (iwait) begin
        en_row = 7'b0111110;
        cause  = 2'd1;
      end
    end
    i_pend_n      = bus.imem_resp ? 1'b0 : (bus.imem_req | i_pend);
    d_pend_n      = bus.dmem_resp ? 1'b0 : (bus.dmem_req | d_pend);
    fetch_state_n = fetch_state_t'({discard_n, i_pend_n});
  end

  always_comb begin
    i_cnt_n = '0;
    d_cnt_n = '0;
    if (i_pend) i_cnt_n = (i_cnt == WD_MAX) ? WD_MAX : i_cnt + WD_W'(1);
    if (d_pend) d_cnt_n = (d_cnt == WD_MAX) ? WD_MAX : d_cnt + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_state <= F_IDLE;
      d_pend      <= 1'b0;
      i_cnt       <= '0;
      d_cnt       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      fetch_state <= fetch_state_n;
      d_pend      <= d_pend_n;
      i_cnt       <= i_cnt_n;
      d_cnt       <= d_cnt_n;
      timeout_q   <= timeout_q | (i_cnt_n == WD_MAX) | (d_cnt_n == WD_MAX);
    end
  end

  assign {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we,
          bus.mem_wb_we, bus.if_id_flush, bus.id_ex_flush} = en_row;
  assign bus.stall_cause   = cause;
  assign bus.fetch_discard = rst_n & discard & bus.imem_resp;
  assign bus.mem_timeout   = timeout_q;

`ifdef PIPE_STALL_PERF_EN
  logic [CNT_W-1:0] perf_i, perf_l, perf_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_i <= '0;
      perf_l <= '0;
      perf_d <= '0;
    end else begin
      if (cause == 2'd1) perf_i <= perf_i + CNT_W'(1);
      if (cause == 2'd2) perf_l <= perf_l + CNT_W'(1);
      if (cause == 2'd3) perf_d <= perf_d + CNT_W'(1);
    end
  end

  assign bus.perf_imem_cnt = perf_i;
  assign bus.perf_lu_cnt   = perf_l;
  assign bus.perf_dmem_cnt = perf_d;
`else
  assign bus.perf_imem_cnt = {CNT_W{1'b0}};
  assign bus.perf_lu_cnt   = {CNT_W{1'b0}};
  assign bus.perf_dmem_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;
  localparam int TB_TO = 4;
  localparam int CNT_W = 32;
`ifdef PIPE_STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, fetch_discard, cause}
  localparam logic [9:0] ROW_OTHER = {7'b1111100, 1'b0, 2'd0};
  localparam logic [9:0] ROW_DMEM  = {7'b0000000, 1'b0, 2'd3};
  localparam logic [9:0] ROW_RED   = {7'b1111111, 1'b0, 2'd0};
  localparam logic [9:0] ROW_LU    = {7'b0011101, 1'b0, 2'd2};
  localparam logic [9:0] ROW_IMEM  = {7'b0111110, 1'b0, 2'd1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipeline_stall_ctrl #(.TIMEOUT(TB_TO), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // behavioural model state
  bit               m_ip, m_dp, m_disc, m_to;
  int               m_irun, m_drun;
  logic [CNT_W-1:0] m_pi, m_pl, m_pd;

  function automatic logic [9:0] got();
    return {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
            bus.if_id_flush, bus.id_ex_flush, bus.fetch_discard, bus.stall_cause};
  endfunction

  function automatic logic [9:0] model_row();
    logic [9:0] r;
    bit dw, iw;
    if (!rst_n) return ROW_OTHER;
    dw = (m_dp || bus.dmem_req) && !bus.dmem_resp;
    iw = (m_ip || bus.imem_req) && (!bus.imem_resp || m_disc);
    if (dw)                       r = ROW_DMEM;
    else if (bus.ex_redirect)     r = ROW_RED;
    else if (bus.load_use_hazard) r = ROW_LU;
    else if (iw)                  r = ROW_IMEM;
    else                          r = ROW_OTHER;
    r[2] = m_disc && bus.imem_resp;
    return r;
  endfunction

  task automatic drive(bit lu, bit red, bit ireq, bit iresp, bit dreq, bit dresp);
    bus.load_use_hazard = lu;
    bus.ex_redirect     = red;
    bus.imem_req        = ireq;
    bus.imem_resp       = iresp;
    bus.dmem_req        = dreq;
    bus.dmem_resp       = dresp;
  endtask

  // advance one clock and move the model along with the DUT
  task automatic tick();
    logic [9:0] r;
    bit dw, iw;
    r  = model_row();
    dw = (m_dp || bus.dmem_req) && !bus.dmem_resp;
    iw = (m_ip || bus.imem_req) && (!bus.imem_resp || m_disc);
    @(posedge clk);
    if (!rst_n) begin
      m_ip = 0; m_dp = 0; m_disc = 0; m_to = 0;
      m_irun = 0; m_drun = 0; m_pi = '0; m_pl = '0; m_pd = '0;
    end else begin
      m_irun = m_ip ? m_irun + 1 : 0;
      m_drun = m_dp ? m_drun + 1 : 0;
      if (m_irun >= TB_TO || m_drun >= TB_TO) m_to = 1;
      if (!dw && bus.ex_redirect && iw) m_disc = 1;
      else if (bus.imem_resp)           m_disc = 0;
      if (bus.imem_resp)     m_ip = 0;
      else if (bus.imem_req) m_ip = 1;
      if (bus.dmem_resp)     m_dp = 0;
      else if (bus.dmem_req) m_dp = 1;
      case (r[1:0])
        2'd1: m_pi = m_pi + 1'b1;
        2'd2: m_pl = m_pl + 1'b1;
        2'd3: m_pd = m_pd + 1'b1;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, 0, 1, 0);
    @(negedge clk);
    checks++;
    if (got() !== ROW_OTHER) begin
      errors++; $display("FAIL reset_during: got %b exp %b", got(), ROW_OTHER);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_timeout !== 1'b0 || got() !== ROW_OTHER) begin
      errors++; $display("FAIL reset_state: timeout %b row %b exp 0 %b", bus.mem_timeout, got(), ROW_OTHER);
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (got() !== ROW_OTHER || bus.perf_dmem_cnt !== '0 || bus.perf_lu_cnt !== '0 || bus.perf_imem_cnt !== '0) begin
      errors++; $display("FAIL reset_release: row %b exp %b", got(), ROW_OTHER);
    end
    tick();
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 1, 1, 0, 0);
      @(negedge clk);
      checks++;
      if (got() !== ROW_OTHER) begin
        errors++; $display("FAIL zero_wait c%0d: got %b exp %b", c, got(), ROW_OTHER);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (got() !== ROW_LU) begin
      errors++; $display("FAIL load_use: got %b exp %b", got(), ROW_LU);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (got() !== ROW_OTHER) begin
      errors++; $display("FAIL load_use_after: got %b exp %b", got(), ROW_OTHER);
    end
    tick();
  endtask

  task automatic test_dmem_wait();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c == 1, 0, 0, 0, c == 0, c == 3);
      @(negedge clk);
      checks++;
      if (got() !== ((c < 3) ? ROW_DMEM : ROW_OTHER)) begin
        errors++; $display("FAIL dmem_wait c%0d: got %b exp %b", c, got(), (c < 3) ? ROW_DMEM : ROW_OTHER);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.perf_dmem_cnt !== (PERF ? 32'd3 : 32'd0) || bus.perf_lu_cnt !== '0) begin
      errors++; $display("FAIL dmem_perf: dmem %0d lu %0d exp %0d 0", bus.perf_dmem_cnt, bus.perf_lu_cnt, PERF ? 3 : 0);
    end
    tick();
  endtask

  task automatic test_redirect_imem();
    logic [9:0] exp_r [5];
    exp_r[0] = ROW_IMEM;
    exp_r[1] = ROW_RED;
    exp_r[2] = ROW_IMEM | 10'b0000000100;
    exp_r[3] = ROW_OTHER;
    exp_r[4] = ROW_OTHER;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(0, c == 1, c == 0, (c == 2) || (c == 4), 0, 0);
      @(negedge clk);
      checks++;
      if (got() !== exp_r[c]) begin
        errors++; $display("FAIL redirect_imem c%0d: got %b exp %b", c, got(), exp_r[c]);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, c == 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (bus.mem_timeout !== (c == 5)) begin
        errors++; $display("FAIL watchdog c%0d: got %b exp %b", c, bus.mem_timeout, c == 5);
      end
      tick();
    end
    drive(0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.mem_timeout !== 1'b1 || got() !== ROW_OTHER) begin
      errors++; $display("FAIL watchdog_sticky: timeout %b row %b exp 1 %b", bus.mem_timeout, got(), ROW_OTHER);
    end
    tick();
  endtask

  // runs straight after the watchdog scenario so mem_timeout is already set
  task automatic test_reset_mid_wait();
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (got() !== ROW_DMEM) begin
      errors++; $display("FAIL mid_wait_pending: got %b exp %b", got(), ROW_DMEM);
    end
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checks++;
    if (got() !== ROW_OTHER) begin
      errors++; $display("FAIL mid_wait_in_reset: got %b exp %b", got(), ROW_OTHER);
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (got() !== ROW_OTHER || bus.mem_timeout !== 1'b0 || bus.perf_dmem_cnt !== '0 ||
        bus.perf_imem_cnt !== '0 || bus.perf_lu_cnt !== '0) begin
      errors++; $display("FAIL mid_wait_after: row %b timeout %b dcnt %0d exp %b 0 0",
                         got(), bus.mem_timeout, bus.perf_dmem_cnt, ROW_OTHER);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (got() !== ROW_OTHER) begin
      errors++; $display("FAIL mid_wait_late_resp: got %b exp %b", got(), ROW_OTHER);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] er;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30);
      @(negedge clk);
      er = model_row();
      checks++;
      if (got() !== er) begin
        errors++; $display("FAIL random_row c%0d: got %b exp %b", c, got(), er);
      end
      checks++;
      if (bus.mem_timeout !== m_to) begin
        errors++; $display("FAIL random_timeout c%0d: got %b exp %b", c, bus.mem_timeout, m_to);
      end
      checks++;
      if (bus.perf_imem_cnt !== (PERF ? m_pi : '0) || bus.perf_lu_cnt !== (PERF ? m_pl : '0) ||
          bus.perf_dmem_cnt !== (PERF ? m_pd : '0)) begin
        errors++; $display("FAIL random_perf c%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", c,
                           bus.perf_imem_cnt, bus.perf_lu_cnt, bus.perf_dmem_cnt,
                           PERF ? m_pi : '0, PERF ? m_pl : '0, PERF ? m_pd : '0);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_zero_wait();
    test_load_use();
    test_dmem_wait();
    test_redirect_imem();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
